cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Synthesisable pipeline trace capture unit for the cpu_2432 system. It replaces per-cycle console dumps with an on-chip circular record buffer.
- Each capture cycle it samples the per-stage PC, opcode and stage-valid of NSTAGES pipeline stages, plus a timestamp.
- It supports continuous, triggered (PC match with post-trigger count) and one-shot modes.
- Records are read back oldest-first through a pop interface. The unit sits beside cpu_0 inside system and is also instantiated by system_tb for post-mortem dumps.

Parameters:
- NSTAGES, 2, number of pipeline stages traced (1..4).
- PC_W, 16, PC width per stage.
- OP_W, 5, opcode width per stage.
- TS_W, 16, timestamp width.
- AW, 6, address width; DEPTH = 2**AW records.
- REC_W, TS_W+NSTAGES*(1+PC_W+OP_W), record width (derived, not overridable).

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, synchronous active-high reset.
- i_clk_en, input, 1, clock enable; qualifies capture and timestamp; the readout path ignores it.
- i_stage_valid, input, NSTAGES, per-stage valid; bit 0 = P0.
- i_stage_pc, input, NSTAGES*PC_W, packed PCs; stage k at [k*PC_W +: PC_W].
- i_stage_opcode, input, NSTAGES*OP_W, packed opcodes.
- i_cfg_mode, input, 2, 0=CONT, 1=TRIG, 2=ONESHOT, 3=reserved (behaves as CONT).
- i_cfg_trig_pc, input, PC_W, trigger PC (TRIG mode).
- i_cfg_post, input, AW, number of records captured after the trigger record.
- i_arm, input, 1, single-cycle pulse: clear buffer and start capture.
- i_stop, input, 1, single-cycle pulse: force DONE.
- i_rd_req, input, 1, pop one record.
- o_rd_data, output, REC_W, popped record: {ts, stage N-1 .. stage 0 as {valid, pc, opcode}}.
- o_rd_valid, output, 1, o_rd_data valid this cycle.
- o_rd_empty, output, 1, no unread records remain.
- o_state, output, 2, 0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- o_count, output, AW+1, records held (0..DEPTH).
- o_triggered, output, 1, trigger has fired since the last arm.

Behaviour:
- Reset values: o_state=IDLE, o_count=0, o_triggered=0, o_rd_valid=0, o_rd_data=0, o_rd_empty=1. Write pointer, read pointer, post counter and timestamp are all 0.
- Timestamp: increments by 1 on every i_clk_en cycle from reset and wraps modulo 2**TS_W. It is not cleared by i_arm.
- Capture condition: state in {ARMED, POST}, i_clk_en=1 and |i_stage_valid. The record is written at wr_ptr and wr_ptr increments modulo DEPTH. o_count increments, saturating at DEPTH. The record is visible to readout one cycle later.
- IDLE: no capture. i_arm -> ARMED.
- ARMED:
  - CONT: captures and overwrites the oldest record when full.
  - ONESHOT: the capture that makes o_count==DEPTH moves to DONE.
  - TRIG: trigger = capture cycle with i_stage_valid[0] and stage-0 PC == i_cfg_trig_pc. The trigger record is captured and o_triggered=1. If i_cfg_post==0 -> DONE, else -> POST with post_cnt=i_cfg_post.
- POST: each capture decrements post_cnt; the capture that makes it 0 -> DONE. Further PC matches are ignored. Overwrites the oldest record when full.
- Transition into DONE: rd_ptr = (o_count==DEPTH) ? wr_ptr : 0; unread = o_count.
- DONE: frozen, no capture. An i_rd_req with unread>0 issues a RAM read at rd_ptr:
  - o_rd_valid=1 exactly one cycle later, with the data;
  - rd_ptr increments modulo DEPTH and unread decrements.
- o_rd_empty = (unread==0). An i_rd_req while empty or outside DONE is ignored, and o_rd_valid stays 0. Back-to-back pops every cycle are supported.
- i_stop in ARMED or POST -> DONE on the next cycle. The same-cycle capture still completes.
- i_arm from any state -> ARMED next cycle: wr_ptr=0, o_count=0, o_triggered=0, unread=0. Any pending o_rd_valid is dropped.
- Simultaneous events:
  - i_arm beats i_stop.
  - i_stop beats the trigger: the trigger record is captured, and the state becomes DONE with o_triggered=1.
  - In ONESHOT, full and i_stop together -> DONE.
- i_rst mid-operation returns everything to reset values. RAM contents need not be cleared, since o_count gates visibility.

Decomposition:
- Shared header cpu_trace.vh holds the `defines for mode encodings (CONT/TRIG/ONESHOT), state encodings (IDLE/ARMED/POST/DONE) and record field offset macros. system_tb includes it to decode dumps.
- Sub-module trace_dpram: simple dual-port synchronous RAM (REC_W x DEPTH), one write port, one registered read port with 1-cycle latency, no reset on the array.

Test Plan:
- CONT, AW=3, 12 valid cycles with PC=0..11, then i_stop -> o_count=8. Eight pops return PC 4..11 in order; o_rd_empty=1 after the 8th pop; a 9th i_rd_req gives o_rd_valid=0.
- TRIG, trig_pc=0x0040, post=3, PC stream 0x3C,0x3D,...: captures end at PC 0x43; o_state=DONE, o_triggered=1; the last popped record has PC=0x0043.
- ONESHOT, AW=3 -> DONE after exactly 8 captures. Cycles with i_stage_valid=0 and cycles with i_clk_en=0 are not recorded, and timestamps in the records skip accordingly.
- i_arm while in POST with 5 records held -> next cycle o_state=ARMED, o_count=0, o_triggered=0.
- Same-cycle trigger + i_stop -> DONE, o_triggered=1, trigger record present. A same-cycle i_arm + i_stop -> ARMED.
- Apply i_rst mid-readout, with o_rd_valid pending -> next cycle all outputs at reset values and o_state=IDLE.

Source files
------------

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the pipeline trace buffer: state/mode encodings and record geometry.
package cpu_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_TRIG    = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // One stage slice is {valid, pc, opcode}.
  function automatic int unsigned stage_w(input int unsigned pc_w, input int unsigned op_w);
    return 1 + pc_w + op_w;
  endfunction

  // Full record is {ts, stage N-1 .. stage 0}.
  function automatic int unsigned rec_w(input int unsigned nstages, input int unsigned pc_w,
                                        input int unsigned op_w, input int unsigned ts_w);
    return ts_w + nstages * stage_w(pc_w, op_w);
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_dpram.sv
// Simple dual-port record store: one write port, one registered read port (1-cycle latency).
module cpu_trace_buffer_dpram #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];

  // Array is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Pipeline trace capture unit: circular record buffer with continuous, triggered and
// one-shot capture modes, read back oldest-first through a pop interface.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int unsigned NSTAGES = 2,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned AW      = 6,
  localparam int unsigned REC_W  = rec_w(NSTAGES, PC_W, OP_W, TS_W)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clk_en,
  input  logic [NSTAGES-1:0]      i_stage_valid,
  input  logic [NSTAGES*PC_W-1:0] i_stage_pc,
  input  logic [NSTAGES*OP_W-1:0] i_stage_opcode,
  input  logic [1:0]              i_cfg_mode,
  input  logic [PC_W-1:0]         i_cfg_trig_pc,
  input  logic [AW-1:0]           i_cfg_post,
  input  logic                    i_arm,
  input  logic                    i_stop,
  input  logic                    i_rd_req,
  output logic [REC_W-1:0]        o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_empty,
  output logic [1:0]              o_state,
  output logic [AW:0]             o_count,
  output logic                    o_triggered
);

  localparam int unsigned SW    = stage_w(PC_W, OP_W);
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  state_e            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     post_cnt;
  logic [AW:0]       count;
  logic [AW:0]       unread;
  logic [TS_W-1:0]   ts;
  logic              triggered;
  logic              rd_valid;
  logic              rd_empty;

  logic              cap;
  logic              trig;
  logic              to_done;
  logic              rd_en;
  logic [AW-1:0]     wr_ptr_nxt;
  logic [AW:0]       count_nxt;
  logic [REC_W-1:0]  rec;

  // Record assembly: timestamp on top, stage 0 in the low slice.
  always_comb begin
    rec = '0;
    rec[REC_W-1 -: TS_W] = ts;
    for (int k = 0; k < NSTAGES; k++) begin
      rec[k*SW +: SW] = {i_stage_valid[k], i_stage_pc[k*PC_W +: PC_W], i_stage_opcode[k*OP_W +: OP_W]};
    end
  end

  // Capture/trigger qualification and the DONE entry condition (uses post-capture count).
  always_comb begin
    cap        = (state == ST_ARMED || state == ST_POST) && i_clk_en && (|i_stage_valid);
    trig       = cap && (state == ST_ARMED) && (i_cfg_mode == MODE_TRIG) &&
                 i_stage_valid[0] && (i_stage_pc[PC_W-1:0] == i_cfg_trig_pc);
    wr_ptr_nxt = cap ? wr_ptr + AW'(1) : wr_ptr;
    count_nxt  = (cap && count != FULL) ? count + (AW+1)'(1) : count;
    to_done    = 1'b0;
    case (state)
      ST_ARMED: to_done = i_stop || (trig && i_cfg_post == '0) ||
                          ((i_cfg_mode == MODE_ONESHOT) && cap && count_nxt == FULL);
      ST_POST:  to_done = i_stop || (cap && post_cnt == AW'(1));
      default:  to_done = 1'b0;
    endcase
    rd_en = (state == ST_DONE) && i_rd_req && !rd_empty && !i_arm;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      unread    <= '0;
      ts        <= '0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
      rd_empty  <= 1'b1;
    end else begin
      if (i_clk_en) ts <= ts + TS_W'(1);
      rd_valid <= rd_en;
      if (i_arm) begin
        state     <= ST_ARMED;
        wr_ptr    <= '0;
        count     <= '0;
        unread    <= '0;
        triggered <= 1'b0;
        rd_empty  <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr_nxt;
        count  <= count_nxt;
        if (trig) triggered <= 1'b1;
        case (state)
          ST_IDLE: ;
          ST_ARMED: begin
            if (trig && !to_done) begin
              state    <= ST_POST;
              post_cnt <= i_cfg_post;
            end
          end
          ST_POST: begin
            if (cap) post_cnt <= post_cnt - AW'(1);
          end
          ST_DONE: begin
            if (rd_en) begin
              rd_ptr   <= rd_ptr + AW'(1);
              unread   <= unread - (AW+1)'(1);
              rd_empty <= (unread == (AW+1)'(1));
            end
          end
        endcase
        // A wrapped buffer starts reading at the oldest slot, otherwise at slot 0.
        if (to_done) begin
          state    <= ST_DONE;
          rd_ptr   <= (count_nxt == FULL) ? wr_ptr_nxt : '0;
          unread   <= count_nxt;
          rd_empty <= (count_nxt == '0);
        end
      end
    end
  end

  cpu_trace_buffer_dpram #(
    .W  (REC_W),
    .AW (AW)
  ) u_ram (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (cap),
    .waddr (wr_ptr),
    .wdata (rec),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (o_rd_data)
  );

  assign o_rd_valid  = rd_valid;
  assign o_rd_empty  = rd_empty;
  assign o_state     = state;
  assign o_count     = count;
  assign o_triggered = triggered;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (NSTAGES=2, AW=3) with hand-derived expectations.
module tb_cpu_trace_buffer;

  localparam int unsigned AW    = 3;
  localparam int unsigned REC_W = 60;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clk_en = 1'b1;
  logic [1:0]        stage_valid = '0;
  logic [31:0]       stage_pc = '0;
  logic [9:0]        stage_opcode = '0;
  logic [1:0]        cfg_mode = '0;
  logic [15:0]       cfg_trig_pc = '0;
  logic [AW-1:0]     cfg_post = '0;
  logic              arm = 1'b0;
  logic              stop = 1'b0;
  logic              rd_req = 1'b0;
  logic [REC_W-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_empty;
  logic [1:0]        state;
  logic [AW:0]       count;
  logic              triggered;

  int unsigned       n_pass = 0;
  int unsigned       n_total = 0;
  logic [15:0]       ts_m = '0;
  logic [REC_W-1:0]  exp_q [$];

  cpu_trace_buffer #(
    .NSTAGES (2),
    .PC_W    (16),
    .OP_W    (5),
    .TS_W    (16),
    .AW      (AW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clk_en       (clk_en),
    .i_stage_valid  (stage_valid),
    .i_stage_pc     (stage_pc),
    .i_stage_opcode (stage_opcode),
    .i_cfg_mode     (cfg_mode),
    .i_cfg_trig_pc  (cfg_trig_pc),
    .i_cfg_post     (cfg_post),
    .i_arm          (arm),
    .i_stop         (stop),
    .i_rd_req       (rd_req),
    .o_rd_data      (rd_data),
    .o_rd_valid     (rd_valid),
    .o_rd_empty     (rd_empty),
    .o_state        (state),
    .o_count        (count),
    .o_triggered    (triggered)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Timestamp model: cleared by reset, advanced on every enabled edge.
  task automatic tick();
    @(posedge clk);
    if (rst) ts_m = '0;
    else if (clk_en) ts_m = ts_m + 16'd1;
    #1;
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [15:0] ts, input logic [1:0] v,
                                              input logic [15:0] p0, input logic [4:0] o0,
                                              input logic [15:0] p1, input logic [4:0] o1);
    return {ts, v[1], p1, o1, v[0], p0, o0};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [15:0] p0, input logic [4:0] o0,
                       input logic [15:0] p1, input logic [4:0] o1);
    stage_valid  = v;
    stage_pc     = {p1, p0};
    stage_opcode = {o1, o0};
  endtask

  task automatic do_arm(input logic [1:0] mode);
    cfg_mode = mode;
    drive(2'b00, 16'h0, 5'h0, 16'h0, 5'h0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Pops n records back-to-back and compares each against the expected queue.
  task automatic pop_all(input string tag, input int n);
    rd_req = 1'b1;
    for (int j = 0; j < n; j++) begin
      logic [REC_W-1:0] e;
      tick();
      e = exp_q.pop_front();
      check({tag, "_vld"}, 64'(rd_valid), 64'd1);
      check({tag, "_rec"}, 64'(rd_data), 64'(e));
    end
    rd_req = 1'b0;
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_trig", 64'(triggered), 64'd0);
    check("rst_rvld", 64'(rd_valid), 64'd0);
    check("rst_rdata", 64'(rd_data), 64'd0);
    check("rst_empty", 64'(rd_empty), 64'd1);

    // CONT: 12 captures into 8 slots, oldest four overwritten
    do_arm(2'd0);
    check("cont_armed", 64'(state), 64'd1);
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      drive(2'b11, 16'(i), 5'(i), 16'(16'h100 + i), 5'(31 - i));
      if (i >= 4) exp_q.push_back(mk_rec(ts_m, 2'b11, 16'(i), 5'(i), 16'(16'h100 + i), 5'(31 - i)));
      tick();
    end
    drive(2'b00, 16'h0, 5'h0, 16'h0, 5'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_done", 64'(state), 64'd3);
    check("cont_count", 64'(count), 64'd8);
    check("cont_nempty", 64'(rd_empty), 64'd0);
    pop_all("cont_pop", 8);
    check("cont_empty", 64'(rd_empty), 64'd1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("cont_pop9", 64'(rd_valid), 64'd0);

    // TRIG: trigger at 0x40 with three post-trigger records
    cfg_trig_pc = 16'h0040;
    cfg_post    = 3'd3;
    do_arm(2'd1);
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 16'(16'h3C + i), 5'(i), 16'h0, 5'h0);
      if (i <= 7) exp_q.push_back(mk_rec(ts_m, 2'b01, 16'(16'h3C + i), 5'(i), 16'h0, 5'h0));
      tick();
      if (i == 3) check("trig_pre", 64'(triggered), 64'd0);
      if (i == 4) begin
        check("trig_fired", 64'(triggered), 64'd1);
        check("trig_post", 64'(state), 64'd2);
      end
    end
    check("trig_done", 64'(state), 64'd3);
    check("trig_flag", 64'(triggered), 64'd1);
    check("trig_count", 64'(count), 64'd8);
    pop_all("trig_pop", 8);

    // ONESHOT: gaps from stage_valid=0 and clk_en=0 are skipped
    do_arm(2'd2);
    exp_q.delete();
    begin
      int ncap = 0;
      for (int i = 0; i < 20; i++) begin
        logic [1:0] v;
        v = (i % 5 == 3) ? 2'b00 : ((i % 3 == 0) ? 2'b10 : 2'b01);
        clk_en = (i % 4 != 2);
        drive(v, 16'(16'h500 + i), 5'(i), 16'(16'h600 + i), 5'(~i));
        if (ncap < 8 && clk_en && v != 2'b00) begin
          exp_q.push_back(mk_rec(ts_m, v, 16'(16'h500 + i), 5'(i), 16'(16'h600 + i), 5'(~i)));
          ncap++;
          tick();
          if (ncap == 7) check("one_7armed", 64'(state), 64'd1);
          if (ncap == 8) check("one_8done", 64'(state), 64'd3);
        end else begin
          tick();
        end
      end
    end
    clk_en = 1'b1;
    drive(2'b00, 16'h0, 5'h0, 16'h0, 5'h0);
    check("one_count", 64'(count), 64'd8);
    pop_all("one_pop", 8);

    // Re-arm while in POST holding five records
    cfg_trig_pc = 16'h0200;
    cfg_post    = 3'd7;
    do_arm(2'd1);
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 16'(16'h1FE + i), 5'h1, 16'h0, 5'h0);
      tick();
    end
    check("post_state", 64'(state), 64'd2);
    check("post_count", 64'(count), 64'd5);
    drive(2'b01, 16'h0203, 5'h1, 16'h0, 5'h0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    drive(2'b00, 16'h0, 5'h0, 16'h0, 5'h0);
    check("rearm_state", 64'(state), 64'd1);
    check("rearm_count", 64'(count), 64'd0);
    check("rearm_trig", 64'(triggered), 64'd0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("rearm_noread", 64'(rd_valid), 64'd0);

    // Trigger and stop in the same cycle
    exp_q.delete();
    drive(2'b01, 16'h01FF, 5'h2, 16'h0, 5'h0);
    exp_q.push_back(mk_rec(ts_m, 2'b01, 16'h01FF, 5'h2, 16'h0, 5'h0));
    tick();
    drive(2'b01, 16'h0200, 5'h3, 16'h0, 5'h0);
    exp_q.push_back(mk_rec(ts_m, 2'b01, 16'h0200, 5'h3, 16'h0, 5'h0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drive(2'b00, 16'h0, 5'h0, 16'h0, 5'h0);
    check("ts_state", 64'(state), 64'd3);
    check("ts_trig", 64'(triggered), 64'd1);
    check("ts_count", 64'(count), 64'd2);
    pop_all("ts_pop", 2);
    arm  = 1'b1;
    stop = 1'b1;
    tick();
    arm  = 1'b0;
    stop = 1'b0;
    check("armstop", 64'(state), 64'd1);

    // Reset during readout with a pop result pending
    cfg_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 16'(16'h700 + i), 5'h4, 16'h0, 5'h0);
      tick();
    end
    drive(2'b00, 16'h0, 5'h0, 16'h0, 5'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    rd_req = 1'b1;
    tick();
    check("mid_vld", 64'(rd_valid), 64'd1);
    check("mid_pc", 64'(rd_data[20:5]), 64'h700);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    check("mrst_state", 64'(state), 64'd0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_trig", 64'(triggered), 64'd0);
    check("mrst_rvld", 64'(rd_valid), 64'd0);
    check("mrst_rdata", 64'(rd_data), 64'd0);
    check("mrst_empty", 64'(rd_empty), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
